// File: rtl/wb_peripheral_router.sv
// Wishbone device-side router: decodes the granted controller bus onto four peripherals,
// returns ack/data, and converts unmapped or silent accesses into a one-cycle error.
module wb_peripheral_router #(
  parameter int ADDR_WIDTH     = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_cyc_i,
  input  logic                  ctrl_stb_i,
  input  logic                  ctrl_we_i,
  input  logic [3:0]            ctrl_sel_i,
  input  logic [ADDR_WIDTH-1:0] ctrl_adr_i,
  input  logic [31:0]           ctrl_dat_w_i,
  output logic                  ctrl_ack_o,
  output logic                  ctrl_err_o,
  output logic [31:0]           ctrl_dat_r_o,
  output logic [3:0]            dev_cyc_o,
  output logic [3:0]            dev_stb_o,
  output logic                  dev_we_o,
  output logic [3:0]            dev_sel_o,
  output logic [ADDR_WIDTH-5:0] dev_adr_o,
  output logic [31:0]           dev_dat_w_o,
  input  logic [3:0]            dev_ack_i,
  input  logic [127:0]          dev_dat_r_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;

  logic       req;
  logic [3:0] req_idx;
  logic       sel_ack;
  logic       timed_out;

  assign req       = ctrl_cyc_i & ctrl_stb_i;
  assign req_idx   = ctrl_adr_i[ADDR_WIDTH-1 -: 4];
  assign sel_ack   = dev_ack_i[idx_q];
  assign timed_out = (timer_q == TIMEOUT);

  assign dev_we_o    = ctrl_we_i;
  assign dev_sel_o   = ctrl_sel_i;
  assign dev_adr_o   = ctrl_adr_i[ADDR_WIDTH-5:0];
  assign dev_dat_w_o = ctrl_dat_w_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Only indices 0..3 reach ACTIVE, so two index bits are enough to steer the mux.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = req_idx[1:0];
          timer_d = 8'd0;
          state_d = (req_idx < 4'd4) ? ACTIVE : ERROR;
        end
      end
      ACTIVE: begin
        if (!ctrl_cyc_i || sel_ack || timed_out) state_d = IDLE;
        else                                   timer_d = timer_q + 8'd1;
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack/err are suppressed while rst is high so a reset never completes a transfer.
  always_comb begin
    ctrl_ack_o   = 1'b0;
    ctrl_err_o   = 1'b0;
    ctrl_dat_r_o = 32'd0;
    dev_cyc_o    = 4'd0;
    dev_stb_o    = 4'd0;
    case (state_q)
      ACTIVE: begin
        if (ctrl_cyc_i) begin
          if (sel_ack || !timed_out) begin
            dev_cyc_o = ctrl_stb_i ? (4'b0001 << idx_q) : 4'd0;
            dev_stb_o = dev_cyc_o;
          end
          if (sel_ack) begin
            ctrl_ack_o = !rst;
            if (!rst) ctrl_dat_r_o = dev_dat_r_i[{idx_q, 5'd0} +: 32];
          end else if (timed_out) begin
            ctrl_err_o = !rst;
          end
        end
      end
      ERROR:   ctrl_err_o = ctrl_cyc_i & !rst;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_peripheral_router.sv
// Directed bench for wb_peripheral_router: transaction-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_wb_peripheral_router;

  localparam int AW  = 28;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_cyc, ctrl_stb, ctrl_we;
  logic [3:0]    ctrl_sel;
  logic [AW-1:0] ctrl_adr;
  logic [31:0]   ctrl_dat_w;
  logic          ctrl_ack, ctrl_err;
  logic [31:0]   ctrl_dat_r;
  logic [3:0]    dev_cyc, dev_stb;
  logic          dev_we;
  logic [3:0]    dev_sel;
  logic [AW-5:0] dev_adr;
  logic [31:0]   dev_dat_w;
  logic [3:0]    dev_ack;
  logic [127:0]  dev_dat_r;

  int n_checks = 0;
  int n_errors = 0;
  int n_ack = 0, n_err = 0, n_stb1 = 0;

  wb_peripheral_router #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .ctrl_cyc_i(ctrl_cyc), .ctrl_stb_i(ctrl_stb), .ctrl_we_i(ctrl_we),
    .ctrl_sel_i(ctrl_sel), .ctrl_adr_i(ctrl_adr), .ctrl_dat_w_i(ctrl_dat_w),
    .ctrl_ack_o(ctrl_ack), .ctrl_err_o(ctrl_err), .ctrl_dat_r_o(ctrl_dat_r),
    .dev_cyc_o(dev_cyc), .dev_stb_o(dev_stb), .dev_we_o(dev_we),
    .dev_sel_o(dev_sel), .dev_adr_o(dev_adr), .dev_dat_w_o(dev_dat_w),
    .dev_ack_i(dev_ack), .dev_dat_r_i(dev_dat_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transfer described by who it targets and how long it has waited.
  bit m_started = 0;
  bit m_busy = 0;
  bit m_err_pend = 0;
  int m_dev = 0;
  int m_age = 0;

  function automatic logic [31:0] dev_word(input int d);
    return dev_dat_r[d*32 +: 32];
  endfunction

  always @(posedge clk) begin
    m_started = 1;
    if (rst) begin
      m_busy = 0; m_err_pend = 0; m_age = 0;
    end else if (m_err_pend) begin
      m_err_pend = 0;
    end else if (m_busy) begin
      if (!ctrl_cyc || dev_ack[m_dev] || m_age == TMO) m_busy = 0;
      else m_age++;
    end else if (ctrl_cyc && ctrl_stb) begin
      m_dev = int'(ctrl_adr[AW-1 -: 4]);
      if (m_dev < 4) begin m_busy = 1; m_age = 0; end
      else m_err_pend = 1;
    end
  end

  always @(negedge clk) begin
    logic [3:0]  e_stb;
    logic        e_ack, e_err;
    logic [31:0] e_dat;
    if (m_started) begin
      e_stb = 4'd0; e_ack = 1'b0; e_err = 1'b0; e_dat = 32'd0;
      if (m_err_pend) begin
        e_err = ctrl_cyc && !rst;
      end else if (m_busy && ctrl_cyc) begin
        if (dev_ack[m_dev]) begin
          e_ack = !rst;
          e_dat = e_ack ? dev_word(m_dev) : 32'd0;
          e_stb = ctrl_stb ? (4'b0001 << m_dev) : 4'd0;
        end else if (m_age == TMO) begin
          e_err = !rst;
        end else begin
          e_stb = ctrl_stb ? (4'b0001 << m_dev) : 4'd0;
        end
      end
      chk("m_ack", 32'(ctrl_ack), 32'(e_ack));
      chk("m_err", 32'(ctrl_err), 32'(e_err));
      chk("m_dat_r", ctrl_dat_r, e_dat);
      chk("m_dev_stb", 32'(dev_stb), 32'(e_stb));
      chk("m_dev_cyc", 32'(dev_cyc), 32'(e_stb));
      chk("m_dev_we", 32'(dev_we), 32'(ctrl_we));
      chk("m_dev_sel", 32'(dev_sel), 32'(ctrl_sel));
      chk("m_dev_adr", 32'(dev_adr), 32'(ctrl_adr[AW-5:0]));
      chk("m_dev_dat_w", dev_dat_w, ctrl_dat_w);
      chk("m_ack_err_excl", 32'(ctrl_ack & ctrl_err), 32'd0);
      if (ctrl_ack) n_ack++;
      if (ctrl_err) n_err++;
      if (dev_stb[1]) n_stb1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drop_bus();
    ctrl_cyc = 1'b0; ctrl_stb = 1'b0; ctrl_we = 1'b0; dev_ack = 4'd0;
  endtask

  task automatic request(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dw);
    ctrl_cyc = 1'b1; ctrl_stb = 1'b1; ctrl_we = we;
    ctrl_sel = sel; ctrl_adr = adr; ctrl_dat_w = dw;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    ctrl_cyc = 1'b0; ctrl_stb = 1'b0; ctrl_we = 1'b0;
    ctrl_sel = 4'hF; ctrl_adr = '0; ctrl_dat_w = 32'd0; dev_ack = 4'd0;
    dev_dat_r = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

    repeat (3) step();
    settle();
    chk("rst_ack", 32'(ctrl_ack), 32'd0);
    chk("rst_err", 32'(ctrl_err), 32'd0);
    chk("rst_stb", 32'(dev_stb), 32'd0);
    chk("rst_dat_r", ctrl_dat_r, 32'd0);
    rst = 1'b0;
    step();

    // Read from device 2 with a three-cycle device latency.
    base = n_ack;
    dev_dat_r[95:64] = 32'hCAFEF00D;
    request(28'h2000010, 1'b0, 4'hF, 32'h0);
    settle();
    chk("rd_decode_no_stb", 32'(dev_stb), 32'd0);
    step();
    settle();
    chk("rd_stb", 32'(dev_stb), 32'h4);
    chk("rd_adr", 32'(dev_adr), 32'h10);
    repeat (3) step();
    dev_ack = 4'b0100;
    settle();
    chk("rd_ack", 32'(ctrl_ack), 32'd1);
    chk("rd_dat", ctrl_dat_r, 32'hCAFEF00D);
    step();
    drop_bus();
    settle();
    chk("rd_ack_once", 32'(n_ack - base), 32'd1);
    chk("rd_idle_stb", 32'(dev_stb), 32'd0);

    // Write to device 0, then a back-to-back request to device 1 that times out.
    request(28'h0000044, 1'b1, 4'b0011, 32'h12345678);
    step();
    settle();
    chk("wr_stb", 32'(dev_stb), 32'h1);
    chk("wr_we", 32'(dev_we), 32'd1);
    chk("wr_sel", 32'(dev_sel), 32'h3);
    chk("wr_dat_w", dev_dat_w, 32'h12345678);
    dev_ack = 4'b0001;
    #1;
    chk("wr_ack", 32'(ctrl_ack), 32'd1);
    step();
    request(28'h1000000, 1'b0, 4'hF, 32'h0);
    dev_ack = 4'b1000;
    settle();
    chk("b2b_idle_stb", 32'(dev_stb), 32'd0);
    chk("b2b_idle_ack", 32'(ctrl_ack), 32'd0);
    base = n_stb1;
    step();
    for (int i = 0; i < TMO; i++) begin
      settle();
      chk("to_stb", 32'(dev_stb), 32'h2);
      chk("to_stray_ack", 32'(ctrl_ack), 32'd0);
      step();
    end
    settle();
    chk("to_err", 32'(ctrl_err), 32'd1);
    chk("to_err_stb", 32'(dev_stb), 32'd0);
    base = n_stb1 - base;
    step();
    drop_bus();
    settle();
    chk("to_stb_cycles", 32'(base), 32'(TMO));
    chk("to_err_clear", 32'(ctrl_err), 32'd0);

    // Unmapped index 5.
    base = n_err;
    request(28'h5000000, 1'b0, 4'hF, 32'h0);
    settle();
    chk("um_req_err", 32'(ctrl_err), 32'd0);
    step();
    settle();
    chk("um_err", 32'(ctrl_err), 32'd1);
    chk("um_stb", 32'(dev_stb), 32'd0);
    step();
    drop_bus();
    settle();
    chk("um_err_once", 32'(n_err - base), 32'd1);

    // Abort by dropping cyc, then reset mid-transfer, then a clean device 3 transfer.
    base = n_ack + n_err;
    request(28'h3000000, 1'b0, 4'hF, 32'h0);
    repeat (2) step();
    settle();
    chk("ab_stb", 32'(dev_stb), 32'h8);
    ctrl_cyc = 1'b0;
    dev_ack = 4'b1000;
    settle();
    chk("ab_stb_drop", 32'(dev_stb), 32'd0);
    chk("ab_no_ack", 32'(ctrl_ack), 32'd0);
    step();
    dev_ack = 4'd0;
    ctrl_cyc = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ctrl_adr = 28'h3000ABC;
    settle();
    chk("rs_stb_drop", 32'(dev_stb), 32'd0);
    chk("rs_no_resp", 32'(n_ack + n_err - base), 32'd0);
    dev_dat_r[127:96] = 32'h0BADBEEF;
    step();
    settle();
    chk("d3_stb", 32'(dev_stb), 32'h8);
    chk("d3_adr", 32'(dev_adr), 32'hABC);
    dev_ack = 4'b1000;
    #1;
    chk("d3_ack", 32'(ctrl_ack), 32'd1);
    chk("d3_dat", ctrl_dat_r, 32'h0BADBEEF);
    step();
    drop_bus();
    step();

    // Ack lands on the timeout cycle: ack wins.
    dev_dat_r[31:0] = 32'h600DF00D;
    request(28'h0000100, 1'b0, 4'hF, 32'h0);
    step();
    repeat (TMO) step();
    dev_ack = 4'b0001;
    settle();
    chk("tw_ack", 32'(ctrl_ack), 32'd1);
    chk("tw_no_err", 32'(ctrl_err), 32'd0);
    chk("tw_dat", ctrl_dat_r, 32'h600DF00D);
    step();
    drop_bus();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
